// File: rtl/mc_sequencer_pkg.sv
// mc_pkg: opcodes, ALU operation codes and sequencer state encodings
package mc_pkg;
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_SLT  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_BEQ  = 5'b01000;
    localparam logic [4:0] OP_BNE  = 5'b01001;
    localparam logic [4:0] OP_BR   = 5'b01010;
    localparam logic [4:0] OP_HALT = 5'b11111;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5
    } state_t;
endpackage

// File: rtl/mc_sequencer_decode.sv
// mc_decode: combinational map from the latched opcode to static datapath controls
module mc_decode
    import mc_pkg::*;
(
    input  logic [4:0] ir_op,
    output logic       reg_src,
    output logic       alu_src,
    output logic       wr_src,
    output logic [2:0] alu_op,
    output logic       is_illegal,
    output logic       is_mem,
    output logic       is_branch,
    output logic       writes_reg
);
    logic is_rtype;
    // R-type opcodes share their low bits with the ALU operation code
    always_comb begin
        is_rtype   = ir_op <= OP_SLT;
        is_mem     = (ir_op == OP_LW) || (ir_op == OP_SW);
        is_branch  = (ir_op == OP_BEQ) || (ir_op == OP_BNE) || (ir_op == OP_BR);
        is_illegal = (ir_op > OP_BR) && (ir_op != OP_HALT);
        writes_reg = is_rtype || (ir_op == OP_ADDI) || (ir_op == OP_LW);
        reg_src    = is_rtype;
        alu_src    = (ir_op == OP_ADDI) || is_mem;
        wr_src     = ir_op != OP_LW;
        alu_op     = is_rtype ? ir_op[2:0] :
                     ((ir_op == OP_BEQ) || (ir_op == OP_BNE)) ? ALU_SUB : ALU_ADD;
    end
endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle FETCH/EXEC/MEM/WB control sequencer with run/step/halt
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter bit ILLEGAL_HALTS = 1'b1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [4:0]       INST,
    input  logic             Zero,
    input  logic             RUN,
    input  logic             STEP,
    output logic             PCSrc,
    output logic             RegSrc,
    output logic             RegWrEn,
    output logic             ALUSrc,
    output logic [2:0]       ALUopcode,
    output logic             DmemWrEn,
    output logic             WrSrc,
    output logic             PCEn,
    output logic             HALTED,
    output logic             ILLEGAL,
    output logic [2:0]       STATE,
    output logic [CNT_W-1:0] INSTR_CNT
);
    state_t           state_q, state_d;
    logic [4:0]       ir_op_q, ir_op_d;
    logic             single_q, single_d;
    logic             br_taken_q, br_taken_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_illegal, is_mem, is_branch, writes_reg;

    mc_decode u_decode (
        .ir_op      (ir_op_q),
        .reg_src    (RegSrc),
        .alu_src    (ALUSrc),
        .wr_src     (WrSrc),
        .alu_op     (ALUopcode),
        .is_illegal (is_illegal),
        .is_mem     (is_mem),
        .is_branch  (is_branch),
        .writes_reg (writes_reg)
    );

    // next state; branch outcome is frozen in EXEC so Zero may change during WB
    always_comb begin
        state_d    = state_q;
        ir_op_d    = ir_op_q;
        single_d   = single_q;
        br_taken_d = br_taken_q;
        illegal_d  = illegal_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                state_d  = (RUN || STEP) ? S_FETCH : S_IDLE;
                single_d = (RUN || STEP) ? !RUN : single_q;
            end
            S_FETCH: begin
                ir_op_d = INST;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                br_taken_d = is_branch && ((ir_op_q == OP_BR) || (Zero ^ (ir_op_q == OP_BNE)));
                illegal_d  = illegal_q || is_illegal;
                state_d    = is_mem ? S_MEM :
                             ((ir_op_q == OP_HALT) || (is_illegal && ILLEGAL_HALTS)) ? S_HALT : S_WB;
            end
            S_MEM:   state_d = S_WB;
            S_WB: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (single_q || !RUN) ? S_IDLE : S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            ir_op_q    <= '0;
            single_q   <= 1'b0;
            br_taken_q <= 1'b0;
            illegal_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ir_op_q    <= ir_op_d;
            single_q   <= single_d;
            br_taken_q <= br_taken_d;
            illegal_q  <= illegal_d;
            cnt_q      <= cnt_d;
        end
    end

    // enables are gated by RST_N so a reset edge during MEM/WB commits nothing
    assign PCEn      = RST_N && (state_q == S_WB);
    assign PCSrc     = (state_q == S_WB) && br_taken_q;
    assign RegWrEn   = PCEn && writes_reg;
    assign DmemWrEn  = RST_N && (state_q == S_MEM) && (ir_op_q == OP_SW);
    assign HALTED    = state_q == S_HALT;
    assign ILLEGAL   = illegal_q;
    assign STATE     = state_q;
    assign INSTR_CNT = cnt_q;
endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: instruction-level reference model with directed and random stimulus
module tb_mc_sequencer;
    localparam int CW = 4;
    localparam logic [4:0] ADD = 5'd0, ADDI = 5'd5, LW = 5'd6, SW = 5'd7;
    localparam logic [4:0] BEQ = 5'd8, BNE = 5'd9, BR = 5'd10, HALT = 5'd31;

    logic clk = 1'b0;
    logic rst_n, run, step, zero;
    logic [4:0] inst;
    logic pcsrc, regsrc, regwren, alusrc, dmemwren, wrsrc, pcen, halted, illegal;
    logic [2:0] aluop, state;
    logic [CW-1:0] icnt;

    int checks = 0;
    int errors = 0;

    int mode = 0;
    int k = 0;
    bit m_single, m_br, m_ill;
    logic [4:0] m_ir = 5'd0;
    int m_cnt = 0;

    logic [2:0] s_state;
    logic s_pcen, s_pcsrc, s_regwr, s_dmem, s_halted, s_ill, s_wrsrc, s_alusrc;
    int s_cnt;
    bit rnd_run = 1'b1;
    int hold = 0;

    mc_sequencer #(.CNT_W(CW), .ILLEGAL_HALTS(1'b1)) dut (
        .CLK(clk), .RST_N(rst_n), .INST(inst), .Zero(zero), .RUN(run), .STEP(step),
        .PCSrc(pcsrc), .RegSrc(regsrc), .RegWrEn(regwren), .ALUSrc(alusrc),
        .ALUopcode(aluop), .DmemWrEn(dmemwren), .WrSrc(wrsrc), .PCEn(pcen),
        .HALTED(halted), .ILLEGAL(illegal), .STATE(state), .INSTR_CNT(icnt)
    );

    always #5 clk = ~clk;

    function automatic bit legal(input logic [4:0] op);
        return (op <= BR) || (op == HALT);
    endfunction

    function automatic bit mem_op(input logic [4:0] op);
        return (op == LW) || (op == SW);
    endfunction

    function automatic bit writes(input logic [4:0] op);
        return (op <= ADDI) || (op == LW);
    endfunction

    // {care mask, value} over {RegSrc, ALUSrc, WrSrc, ALUopcode}
    function automatic logic [11:0] spec_ctl(input logic [4:0] op);
        case (op)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4: return {6'b111111, 3'b101, op[2:0]};
            ADDI:     return {6'b011111, 3'b011, 3'b000};
            LW:       return {6'b011111, 3'b010, 3'b000};
            SW:       return {6'b110111, 3'b010, 3'b000};
            BEQ, BNE: return {6'b110111, 3'b000, 3'b001};
            default:  return 12'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit ru, input bit st, input logic [4:0] in, input bit z);
        int len, es;
        bit busy, commit;
        logic [11:0] sc;
        @(negedge clk);
        rst_n = r; run = ru; step = st; inst = in; zero = z;
        #1;
        s_state = state; s_pcen = pcen; s_pcsrc = pcsrc; s_regwr = regwren; s_dmem = dmemwren;
        s_halted = halted; s_ill = illegal; s_wrsrc = wrsrc; s_alusrc = alusrc; s_cnt = int'(icnt);
        busy   = mode == 1;
        len    = mem_op(m_ir) ? 4 : 3;
        commit = busy && k >= 2 && k == len - 1;
        es     = mode == 0 ? 0 : mode == 2 ? 5 : k == 0 ? 1 : k == 1 ? 2 : commit ? 4 : 3;
        chk("STATE", int'(state), es);
        chk("PCEn", int'(pcen), int'(commit && r));
        chk("PCSrc", int'(pcsrc), int'(commit && m_br));
        chk("RegWrEn", int'(regwren), int'(commit && r && writes(m_ir)));
        chk("DmemWrEn", int'(dmemwren), int'(busy && es == 3 && m_ir == SW && r));
        chk("HALTED", int'(halted), int'(mode == 2));
        chk("ILLEGAL", int'(illegal), int'(m_ill));
        chk("INSTR_CNT", int'(icnt), m_cnt);
        sc = spec_ctl(m_ir);
        chk("static_ctl", int'({regsrc, alusrc, wrsrc, aluop} & sc[11:6]), int'(sc[5:0] & sc[11:6]));
        @(posedge clk);
        if (!r) begin
            mode = 0; m_ir = 5'd0; m_ill = 1'b0; m_cnt = 0;
        end else if (mode == 0) begin
            if (ru || st) begin mode = 1; k = 0; m_single = !ru; end
        end else if (mode == 1) begin
            if (k == 0) begin
                m_ir = in; k = 1;
            end else if (k == 1) begin
                m_br = (m_ir == BEQ && z) || (m_ir == BNE && !z) || (m_ir == BR);
                if (!legal(m_ir)) m_ill = 1'b1;
                if (!legal(m_ir) || m_ir == HALT) mode = 2; else k = 2;
            end else if (commit) begin
                m_cnt = (m_cnt + 1) % (1 << CW);
                if (m_single || !ru) mode = 0; else k = 0;
            end else k++;
        end
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b1; step = 1'b0; inst = 5'd0; zero = 1'b0;
        repeat (2) @(posedge clk);
        cyc(0, 1, 0, ADD, 0); chk("d_rst_state", s_state, 0);
        cyc(0, 1, 0, ADD, 0); chk("d_rst_pcen", s_pcen, 0);
        cyc(0, 1, 0, ADD, 0); chk("d_rst_cnt", s_cnt, 0);
        cyc(1, 1, 0, ADDI, 0); chk("d_idle", s_state, 0);
        cyc(1, 1, 0, ADDI, 0); chk("d_fetch", s_state, 1);
        cyc(1, 1, 0, LW, 0);   chk("d_exec_alusrc", s_alusrc, 1);
        cyc(1, 1, 0, LW, 0);   chk("d_addi_pcen", s_pcen, 1); chk("d_addi_regwr", s_regwr, 1); chk("d_addi_wrsrc", s_wrsrc, 1);
        cyc(1, 1, 0, LW, 0);
        cyc(1, 0, 0, ADD, 0);
        cyc(1, 0, 0, ADD, 0);  chk("d_lw_mem", s_state, 3);
        cyc(1, 0, 0, ADD, 0);  chk("d_lw_regwr", s_regwr, 1); chk("d_lw_wrsrc", s_wrsrc, 0);
        cyc(1, 0, 0, ADD, 0);  chk("d_lw_idle", s_state, 0); chk("d_cnt2", s_cnt, 2);
        cyc(1, 0, 1, SW, 0);
        cyc(1, 0, 0, SW, 0);
        cyc(1, 0, 0, ADD, 0);
        cyc(1, 0, 0, ADD, 0);  chk("d_sw_dmem", s_dmem, 1); chk("d_sw_regwr_mem", s_regwr, 0);
        cyc(1, 0, 0, ADD, 0);  chk("d_sw_dmem_wb", s_dmem, 0); chk("d_sw_pcen", s_pcen, 1); chk("d_sw_regwr_wb", s_regwr, 0);
        cyc(1, 0, 0, ADD, 0);  chk("d_sw_idle", s_state, 0);
        cyc(1, 0, 1, BEQ, 0);
        cyc(1, 0, 0, BEQ, 0);
        cyc(1, 0, 0, BEQ, 1);
        cyc(1, 0, 0, BEQ, 0);  chk("d_beq_pcsrc", s_pcsrc, 1);
        cyc(1, 0, 1, BNE, 0);
        cyc(1, 0, 0, BNE, 0);
        cyc(1, 0, 0, BNE, 1);
        cyc(1, 0, 0, BNE, 0);  chk("d_bne_pcsrc", s_pcsrc, 0); chk("d_bne_pcen", s_pcen, 1);
        cyc(1, 0, 1, ADD, 0);
        cyc(1, 0, 0, ADD, 0);
        cyc(1, 0, 1, ADD, 0);
        cyc(1, 0, 0, ADD, 0);  chk("d_step_commit", s_pcen, 1);
        cyc(1, 0, 0, ADD, 0);  chk("d_step_idle", s_state, 0); chk("d_cnt6", s_cnt, 6);
        cyc(1, 0, 0, ADD, 0);  chk("d_step_stay", s_state, 0);
        cyc(1, 1, 0, 5'b10110, 0);
        cyc(1, 1, 0, 5'b10110, 0);
        cyc(1, 1, 1, ADD, 0);
        cyc(1, 1, 1, ADD, 0);  chk("d_ill_halted", s_halted, 1); chk("d_ill_flag", s_ill, 1); chk("d_ill_pcen", s_pcen, 0);
        repeat (3) cyc(1, 1, 1, ADD, 0);
        chk("d_halt_stay", s_state, 5);
        cyc(0, 1, 0, ADD, 0);
        cyc(1, 0, 0, ADD, 0);  chk("d_ill_clr", s_ill, 0); chk("d_halt_clr", s_halted, 0);
        cyc(1, 1, 0, HALT, 0);
        cyc(1, 1, 0, HALT, 0);
        cyc(1, 1, 0, ADD, 0);
        cyc(1, 1, 0, ADD, 0);  chk("d_halt_op", s_halted, 1); chk("d_halt_noill", s_ill, 0);
        cyc(0, 1, 0, ADD, 0);
        cyc(1, 1, 0, ADDI, 0);
        cyc(1, 1, 0, ADDI, 0);
        cyc(1, 1, 0, ADDI, 0);
        cyc(0, 1, 0, ADDI, 0); chk("d_rstwb_state", s_state, 4); chk("d_rstwb_pcen", s_pcen, 0); chk("d_rstwb_regwr", s_regwr, 0);
        cyc(1, 0, 0, ADD, 0);  chk("d_rstwb_cnt", s_cnt, 0);
        for (int i = 0; i < 3000; i++) begin
            bit r;
            int p;
            logic [4:0] op;
            r = !(($urandom_range(0, 249) == 0) || (mode == 2 && hold > 8));
            hold = (mode == 2) ? hold + 1 : 0;
            if ($urandom_range(0, 19) == 0) rnd_run = !rnd_run;
            p = int'($urandom_range(0, 99));
            op = p < 2 ? HALT : p < 3 ? 5'(11 + $urandom_range(0, 19)) : 5'($urandom_range(0, 10));
            cyc(r, rnd_run, $urandom_range(0, 7) == 0, op, $urandom_range(0, 1) == 1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
